dec_mpp_pipe: RTL and testbench

DEC_MPP_PIPE -- requirements
Module: dec_mpp_pipe

---
 rtl/dec_mpp_pipe.sv | 152 +++++++++++++++
 tb/tb_dec_mpp_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_mpp_pipe.sv
// Midpoint-prediction (MPP) block reconstruction pipeline.
//
// Takes one 16-pixel block per handshake. The block carries quantised residuals
// spread over NCOMP+1 substreams, a quantisation step, and the previously
// reconstructed neighbour block. The reconstructed block comes out after two
// register stages.
//   clk, rstn          : clock (rising edge) and asynchronous active-low reset
//   in_vld / in_rdy    : input block handshake
//   in_sol, in_fls     : start-of-line and first-line-of-slice flags
//   in_step            : MPP step size, 0..BPC-1
//   in_qres            : substream residuals, substream s sample j at [(s*16+j)*QW +: QW]
//   prev_rec           : neighbour block, comp c pixel p at [(c*16+p)*(BPC+1) +: BPC+1]
//   out_vld / out_rdy  : output block handshake
//   out_rec            : reconstructed block, same layout as prev_rec
//   blk_cnt            : accepted-block counter, wraps at 16 bits
module dec_mpp_pipe #(
  parameter int BPC   = 8,
  parameter int NCOMP = 3,
  parameter int QW    = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic                        in_sol,
  input  logic                        in_fls,
  input  logic [3:0]                  in_step,
  input  logic [(NCOMP+1)*16*QW-1:0]  in_qres,
  input  logic [NCOMP*16*(BPC+1)-1:0] prev_rec,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [NCOMP*16*(BPC+1)-1:0] out_rec,
  output logic [15:0]                 blk_cnt
);

  localparam int PW = BPC + 1;       // stored pixel width
  localparam int IW = BPC + QW + 2;  // reconstruction width, cannot overflow
  localparam int SW = BPC + 6;       // 16-pixel sum width (signed)

  localparam logic signed [SW-1:0] Rnd   = SW'(8);
  localparam logic signed [IW-1:0] Mid0  = IW'(2 ** (BPC - 1));
  localparam logic signed [IW-1:0] HiLim = IW'(2 ** BPC - 1);
  localparam logic signed [IW-1:0] LoLim = IW'(-(2 ** BPC));
  localparam logic signed [IW-1:0] Zero  = '0;

  logic                 s1_full_q;
  logic        [3:0]    s1_step_q;
  logic signed [QW-1:0] s1_res_q [NCOMP][16];
  logic signed [IW-1:0] s1_mid_q [NCOMP];

  logic signed [QW-1:0] res_d [NCOMP][16];
  logic signed [IW-1:0] mid_d [NCOMP];
  logic [NCOMP*16*PW-1:0] rec_d;

  logic s2_adv;
  logic accept;

  // With 3 components the last four substream-0 samples carry nothing.
  if (NCOMP < 4) begin : g_unused
    logic unused_qres;
    assign unused_qres = ^in_qres[16*QW-1:NCOMP*4*QW];
  end

  // Stage 2 may load whenever its current block is gone or leaving.
  assign s2_adv = !out_vld || out_rdy;
  assign in_rdy = !s1_full_q || s2_adv;
  assign accept = in_vld && in_rdy;

  // Demap: pixels 0..3 of every component share substream 0, pixels 4..15
  // come from the component's own substream.
  always_comb begin
    for (int c = 0; c < NCOMP; c++) begin
      for (int p = 0; p < 16; p++) begin
        if (p < 4) res_d[c][p] = in_qres[(c*4+p)*QW +: QW];
        else       res_d[c][p] = in_qres[((c+1)*16+p-4)*QW +: QW];
      end
    end
  end

  // Midpoint per component, including the step-dependent bias.
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] avg;
  logic        [PW-1:0] pix;
  logic signed [IW-1:0] bias;

  always_comb begin
    sum  = '0;
    avg  = '0;
    pix  = '0;
    bias = (in_step != 4'd0) ? (IW'(1) << (in_step - 4'd1)) : '0;
    for (int c = 0; c < NCOMP; c++) begin
      sum = '0;
      for (int p = 0; p < 16; p++) begin
        pix = prev_rec[(c*16+p)*PW +: PW];
        // Component 0 is unsigned, chroma-like components are signed.
        if (c == 0) sum = sum + $signed({{(SW-PW){1'b0}}, pix});
        else        sum = sum + $signed({{(SW-PW){pix[PW-1]}}, pix});
      end
      avg = (sum + Rnd) >>> 4;
      if (in_fls && in_sol) mid_d[c] = ((c == 0) ? Mid0 : Zero) + bias;
      else                  mid_d[c] = $signed({{(IW-SW){avg[SW-1]}}, avg}) + bias;
    end
  end

  // Reconstruction and clipping from the stage-1 registers.
  logic signed [IW-1:0] qx;
  logic signed [IW-1:0] val;

  always_comb begin
    rec_d = '0;
    qx    = '0;
    val   = '0;
    for (int c = 0; c < NCOMP; c++) begin
      for (int p = 0; p < 16; p++) begin
        qx  = $signed({{(IW-QW){s1_res_q[c][p][QW-1]}}, s1_res_q[c][p]});
        val = s1_mid_q[c] + (qx <<< s1_step_q);
        if (val > HiLim)               val = HiLim;
        else if (c == 0 && val < Zero) val = Zero;
        else if (val < LoLim)          val = LoLim;
        rec_d[(c*16+p)*PW +: PW] = val[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_full_q <= 1'b0;
      s1_step_q <= '0;
      for (int c = 0; c < NCOMP; c++) begin
        s1_mid_q[c] <= '0;
        for (int p = 0; p < 16; p++) s1_res_q[c][p] <= '0;
      end
      out_vld <= 1'b0;
      out_rec <= '0;
      blk_cnt <= '0;
    end else begin
      // When in_rdy is high stage 1 is empty or draining this cycle.
      if (in_rdy) s1_full_q <= in_vld;
      if (accept) begin
        s1_res_q  <= res_d;
        s1_mid_q  <= mid_d;
        s1_step_q <= in_step;
        blk_cnt   <= blk_cnt + 16'd1;
      end
      if (s2_adv) begin
        out_vld <= s1_full_q;
        if (s1_full_q) out_rec <= rec_d;
      end
    end
  end

endmodule

// File: tb/tb_dec_mpp_pipe.sv
module tb_dec_mpp_pipe;
  localparam int BPC = 8;
  localparam int QW  = 8;
  localparam int PW  = BPC + 1;
  localparam int W3  = 3 * 16 * PW;
  localparam int W4  = 4 * 16 * PW;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_vld = 1'b0, in_sol = 1'b0, in_fls = 1'b0, out_rdy = 1'b0;
  logic [3:0] in_step = '0;
  logic [5*16*QW-1:0] qres = '0;
  logic [W4-1:0] prev = '0;
  logic in_rdy3, in_rdy4, out_vld3, out_vld4;
  logic [W3-1:0] out_rec3;
  logic [W4-1:0] out_rec4;
  logic [15:0] blk_cnt3, blk_cnt4;

  always #5 clk = ~clk;

  dec_mpp_pipe #(.BPC(BPC), .NCOMP(3), .QW(QW)) dut3 (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy3), .in_sol(in_sol),
    .in_fls(in_fls), .in_step(in_step), .in_qres(qres[4*16*QW-1:0]), .prev_rec(prev[W3-1:0]),
    .out_vld(out_vld3), .out_rdy(out_rdy), .out_rec(out_rec3), .blk_cnt(blk_cnt3)
  );

  dec_mpp_pipe #(.BPC(BPC), .NCOMP(4), .QW(QW)) dut4 (
    .clk(clk), .rstn(rstn), .in_vld(in_vld), .in_rdy(in_rdy4), .in_sol(in_sol),
    .in_fls(in_fls), .in_step(in_step), .in_qres(qres), .prev_rec(prev),
    .out_vld(out_vld4), .out_rdy(out_rdy), .out_rec(out_rec4), .blk_cnt(blk_cnt4)
  );

  // Block currently offered, in plain integers.
  int q_a [5][16];
  int p_a [4][16];
  int stp;
  bit m_sol, m_fls;

  logic [W4-1:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int nacc = 0;
  bit rdy_rand = 1'b0;

  task automatic check(input string name, input logic [W4-1:0] act, input logic [W4-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: midpoint from the neighbour average, residual scaled by 2^step, clipped.
  function automatic logic [W4-1:0] model();
    logic [W4-1:0] r;
    int mid, sum, v, q, lo, hi;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      if (m_fls && m_sol) mid = (c == 0) ? 2 ** (BPC - 1) : 0;
      else begin
        sum = 0;
        for (int p = 0; p < 16; p++) sum += p_a[c][p];
        mid = (sum + 8) >>> 4;
      end
      if (stp > 0) mid += 2 ** (stp - 1);
      hi = 2 ** BPC - 1;
      lo = (c == 0) ? 0 : -(2 ** BPC);
      for (int p = 0; p < 16; p++) begin
        q = (p < 4) ? q_a[0][c*4+p] : q_a[c+1][p-4];
        v = mid + q * (2 ** stp);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        r[(c*16+p)*PW +: PW] = v[PW-1:0];
      end
    end
    return r;
  endfunction

  task automatic pack();
    int t;
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 16; j++) begin
        t = q_a[s][j];
        qres[(s*16+j)*QW +: QW] = t[QW-1:0];
      end
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 16; p++) begin
        t = p_a[c][p];
        prev[(c*16+p)*PW +: PW] = t[PW-1:0];
      end
    in_step = 4'(stp);
    in_sol  = m_sol;
    in_fls  = m_fls;
  endtask

  task automatic clear_blk();
    for (int s = 0; s < 5; s++) for (int j = 0; j < 16; j++) q_a[s][j] = 0;
    for (int c = 0; c < 4; c++) for (int p = 0; p < 16; p++) p_a[c][p] = 0;
    stp = 0;
    m_sol = 1'b0;
    m_fls = 1'b0;
  endtask

  task automatic gen_random();
    for (int s = 0; s < 5; s++)
      for (int j = 0; j < 16; j++) q_a[s][j] = int'($urandom_range(0, 255)) - 128;
    for (int c = 0; c < 4; c++)
      for (int p = 0; p < 16; p++)
        p_a[c][p] = (c == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 511)) - 256;
    stp   = int'($urandom_range(0, BPC - 1));
    m_sol = 1'($urandom_range(0, 1));
    m_fls = 1'($urandom_range(0, 1));
  endtask

  // Garbage on the data inputs while nothing is offered.
  task automatic scramble();
    for (int i = 0; i < 20; i++) qres[i*32 +: 32] = $urandom;
    for (int i = 0; i < 18; i++) prev[i*32 +: 32] = $urandom;
    in_step = 4'($urandom);
    in_sol  = 1'($urandom);
    in_fls  = 1'($urandom);
  endtask

  // One clock: offer a block if wanted, record acceptance at the edge.
  task automatic do_cycle(input bit want);
    bit acc;
    if (!in_vld) begin
      if (want) begin
        gen_random();
        pack();
        in_vld = 1'b1;
      end else scramble();
    end
    @(negedge clk);
    acc = in_vld && in_rdy4;
    check("rdy_match", in_rdy3, in_rdy4);
    @(posedge clk);
    #1;
    if (acc) begin
      exp_q.push_back(model());
      nacc++;
      in_vld = 1'b0;
    end
    if (rdy_rand) out_rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    rdy_rand = 1'b0;
    out_rdy = 1'b1;
    while ((in_vld || exp_q.size() != 0 || out_vld4) && g < 50) begin
      do_cycle(1'b0);
      g++;
    end
    check("drain_done", 1'(g < 50), 1);
  endtask

  // Offer the prepared block into an empty pipe and return what appears.
  task automatic send_look(input string name, output logic [W4-1:0] got);
    int g;
    g = 0;
    pack();
    in_vld = 1'b1;
    while (in_vld && g < 20) begin
      do_cycle(1'b1);
      g++;
    end
    check({name, "_lat1"}, out_vld4, 0);
    do_cycle(1'b0);
    check({name, "_lat2"}, out_vld4, 1);
    got = out_rec4;
  endtask

  // Monitor / scoreboard.
  logic [W4-1:0] held_rec;
  logic [W4-1:0] mon_e;
  bit held = 1'b0;

  always @(negedge clk) begin
    if (!rstn) held = 1'b0;
    else begin
      if (held) begin
        check("stall_vld", out_vld4, 1);
        check("stall_hold", out_rec4, held_rec);
      end
      held = out_vld4 && !out_rdy;
      held_rec = out_rec4;
      check("vld_match", out_vld3, out_vld4);
      if (out_vld4 && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got block %0h expected none", out_rec4);
        end else begin
          mon_e = exp_q.pop_front();
          check("rec4", out_rec4, mon_e);
          check("rec3", out_rec3, mon_e[W3-1:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W4-1:0] got;
    int g;
    int n0;

    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", out_vld4, 0);
    check("rst_cnt", blk_cnt4, 0);
    check("rst_rec4", out_rec4, 0);
    check("rst_rec3", out_rec3, 0);
    rstn = 1'b1;
    check("rst_rdy", in_rdy4, 1);

    // Default midpoint at start of first line.
    clear_blk();
    m_sol = 1'b1;
    m_fls = 1'b1;
    send_look("dflt", got);
    check("dflt_c0", got[0 +: PW], 128);
    check("dflt_c1", got[16*PW +: PW], 0);
    check("dflt_c2", got[(32+9)*PW +: PW], 0);
    drain();

    // Upper clip of component 0.
    clear_blk();
    for (int p = 0; p < 16; p++) p_a[0][p] = 200;
    for (int s = 0; s < 5; s++) for (int j = 0; j < 16; j++) q_a[s][j] = 20;
    stp = 2;
    send_look("hi", got);
    check("hi_p0", got[0 +: PW], 255);
    check("hi_p5", got[5*PW +: PW], 255);
    drain();

    // Lower clip of component 0.
    for (int s = 0; s < 5; s++) for (int j = 0; j < 16; j++) q_a[s][j] = -60;
    send_look("lo", got);
    check("lo_p0", got[0 +: PW], 0);
    check("lo_p7", got[7*PW +: PW], 0);
    drain();

    // Signed lower clip of component 1.
    clear_blk();
    for (int p = 0; p < 16; p++) p_a[1][p] = -100;
    for (int s = 0; s < 5; s++) for (int j = 0; j < 16; j++) q_a[s][j] = -100;
    stp = 1;
    send_look("neg", got);
    check("neg_p0", got[16*PW +: PW], 9'h100);
    check("neg_p10", got[26*PW +: PW], 9'h100);
    drain();

    // Fourth component demap.
    clear_blk();
    q_a[0][12] = 5;
    q_a[0][15] = -3;
    q_a[4][0] = -7;
    q_a[4][11] = 100;
    send_look("c3", got);
    check("c3_p0", got[48*PW +: PW], 5);
    check("c3_p3", got[51*PW +: PW], 9'h1FD);
    check("c3_p4", got[52*PW +: PW], 9'h1F9);
    check("c3_p15", got[63*PW +: PW], 100);
    drain();

    // Backpressure: two blocks held, input stalls.
    out_rdy = 1'b0;
    n0 = nacc;
    repeat (6) do_cycle(1'b1);
    check("bp_accepts", nacc - n0, 2);
    check("bp_rdy", in_rdy4, 0);
    check("bp_vld", out_vld4, 1);
    drain();

    // Random traffic with random backpressure.
    rdy_rand = 1'b1;
    repeat (400) do_cycle($urandom_range(0, 3) != 0);
    drain();
    check("cnt_rand", blk_cnt4, nacc[15:0]);
    check("cnt_rand3", blk_cnt3, nacc[15:0]);

    // Full-rate streaming.
    n0 = nacc;
    repeat (40) do_cycle(1'b1);
    check("full_rate", nacc - n0, 40);

    // Asynchronous reset with blocks in flight.
    #2;
    rstn = 1'b0;
    #1;
    check("arst_vld", out_vld4, 0);
    check("arst_vld3", out_vld3, 0);
    check("arst_cnt", blk_cnt4, 0);
    exp_q.delete();
    in_vld = 1'b0;
    nacc = 0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    check("arst_rdy", in_rdy4, 1);
    repeat (5) do_cycle(1'b0);
    check("arst_quiet", out_vld4, 0);

    // Counter wrap.
    g = 0;
    while (nacc < 65535 && g < 70000) begin
      do_cycle(1'b1);
      g++;
    end
    check("cnt_ffff", blk_cnt4, 16'hFFFF);
    do_cycle(1'b1);
    check("cnt_wrap", blk_cnt4, 0);
    check("cnt_wrap3", blk_cnt3, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
